mem_port_arbiter8: RTL and testbench

//  Round-robin arbiter and sequencer for one shared memory port used by up to 8 pipeline requesters.
//  It picks one requester, drives the 3-bit select of the shared 8:1 address/data mux, and issues the read or write.
//  It holds the grant until the memory responds or a watchdog expires, then pulses done to the winning requester.
//  It sits between the stage requesters and the single memory interface.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick8.sv | 27 ++
 rtl/mem_port_arbiter8.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter8.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the memory-port arbiter: requester count, index type and FSM states.
package arb_pkg;

    localparam int NREQ = 8;

    typedef logic [2:0] req_idx_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01
    } arb_state_t;

    function automatic logic [NREQ-1:0] idx_onehot(input req_idx_t idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo 8.
import arb_pkg::*;

module rr_pick8 (
    input  logic [NREQ-1:0] req,
    input  req_idx_t        ptr,
    output req_idx_t        idx,
    output logic            valid
);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    req_idx_t          off_s;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[NREQ-1:0];
        off_s = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? req_idx_t'(i) : off_s;
        end
        idx   = ptr + off_s;
        valid = |req;
    end

endmodule

// File: rtl/mem_port_arbiter8.sv
// Round-robin arbiter and sequencer for one shared memory port with up to 8 requesters,
// holding the grant until the memory responds or the watchdog expires.
import arb_pkg::*;

module mem_port_arbiter8 #(
    parameter int TIMEOUT     = 255,
    parameter bit FIXED_PRIO0 = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] we,
    input  logic            mem_resp,
    output logic [2:0]      sel,
    output logic [NREQ-1:0] grant,
    output logic            mem_read,
    output logic            mem_write,
    output logic [NREQ-1:0] done,
    output logic            timeout_err
);

    localparam bit         WD_EN       = (TIMEOUT != 0);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    arb_state_t      state_r;
    req_idx_t        rr_ptr_r;
    req_idx_t        sel_r;
    logic [NREQ-1:0] grant_r;
    logic            mem_read_r;
    logic            mem_write_r;
    logic [7:0]      wd_cnt_r;

    req_idx_t        pick_idx_s;
    logic            pick_valid_s;
    req_idx_t        winner_s;
    logic            wd_fire_s;
    logic            finish_s;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (rr_ptr_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Completion decode; gated by rst_n so a reset mid-transaction never reports done.
    always_comb begin
        winner_s  = (FIXED_PRIO0 && req[0]) ? 3'd0 : pick_idx_s;
        wd_fire_s = WD_EN && rst_n && (state_r == ARB_BUSY)
                    && (wd_cnt_r == TIMEOUT_CNT) && !mem_resp;
        finish_s  = rst_n && (state_r == ARB_BUSY) && (mem_resp || wd_fire_s);
    end

    // Arbitration FSM with registered grant, select, strobes and watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ARB_IDLE;
            rr_ptr_r    <= 3'd0;
            sel_r       <= 3'd0;
            grant_r     <= 8'h00;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            wd_cnt_r    <= 8'd0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_valid_s) begin
                        sel_r       <= winner_s;
                        grant_r     <= idx_onehot(winner_s);
                        mem_read_r  <= ~we[winner_s];
                        mem_write_r <= we[winner_s];
                        wd_cnt_r    <= 8'd1;
                        state_r     <= ARB_BUSY;
                    end else begin
                        state_r     <= ARB_IDLE;
                    end
                end
                ARB_BUSY: begin
                    if (finish_s) begin
                        rr_ptr_r    <= sel_r + 3'd1;
                        sel_r       <= 3'd0;
                        grant_r     <= 8'h00;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        wd_cnt_r    <= 8'd0;
                        state_r     <= ARB_IDLE;
                    end else if (wd_cnt_r != 8'hFF) begin
                        wd_cnt_r    <= wd_cnt_r + 8'd1;
                    end else begin
                        wd_cnt_r    <= wd_cnt_r;
                    end
                end
                default: begin
                    sel_r       <= 3'd0;
                    grant_r     <= 8'h00;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    wd_cnt_r    <= 8'd0;
                    state_r     <= ARB_IDLE;
                end
            endcase
        end
    end

    assign sel         = sel_r;
    assign grant       = grant_r;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign done        = finish_s ? grant_r : 8'h00;
    assign timeout_err = wd_fire_s;

endmodule

// File: tb/tb_mem_port_arbiter8.sv
// Directed bench for mem_port_arbiter8: default instance (a) and a fixed-priority,
// short-watchdog instance (b) sharing the same stimulus.
module tb_mem_port_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_resp;
    logic [7:0] req;
    logic [7:0] we;

    logic [2:0] sel_a, sel_b;
    logic [7:0] grant_a, grant_b, done_a, done_b;
    logic       mem_read_a, mem_read_b, mem_write_a, mem_write_b;
    logic       timeout_err_a, timeout_err_b;

    int          checks = 0;
    int          errors = 0;
    logic [21:0] exp_v;
    logic [7:0]  oh;

    always #5 clk = ~clk;

    mem_port_arbiter8 dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .mem_resp(mem_resp),
        .sel(sel_a), .grant(grant_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .done(done_a), .timeout_err(timeout_err_a)
    );

    mem_port_arbiter8 #(.TIMEOUT(4), .FIXED_PRIO0(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .mem_resp(mem_resp),
        .sel(sel_b), .grant(grant_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .done(done_b), .timeout_err(timeout_err_b)
    );

    // Observation vector: {grant, sel, mem_read, mem_write, done, timeout_err}
    function automatic logic [21:0] obs_a();
        return {grant_a, sel_a, mem_read_a, mem_write_a, done_a, timeout_err_a};
    endfunction

    function automatic logic [21:0] obs_b();
        return {grant_b, sel_b, mem_read_b, mem_write_b, done_b, timeout_err_b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'h00; we = 8'h00; mem_resp = 1'b0;
        step(); step(); #1;
        exp_v = 22'h0;
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL reset_a got %h exp %h", obs_a(), exp_v); end
        checks++;
        if (obs_b() !== exp_v) begin errors++; $display("FAIL reset_b got %h exp %h", obs_b(), exp_v); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        test_reset();
        req = 8'h08; we = 8'h00;
        step(); #1;
        exp_v = {8'h08, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0};
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL single_grant got %h exp %h", obs_a(), exp_v); end
        step(); mem_resp = 1'b1; #1;
        exp_v = {8'h08, 3'd3, 1'b1, 1'b0, 8'h08, 1'b0};
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL single_done got %h exp %h", obs_a(), exp_v); end
        step(); mem_resp = 1'b0; req = 8'h00; #1;
        exp_v = 22'h0;
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL single_idle got %h exp %h", obs_a(), exp_v); end
    endtask

    task automatic test_rr_sweep();
        test_reset();
        req = 8'hFF; we = 8'h00;
        for (int k = 0; k < 8; k++) begin
            oh = 8'h01 << k;
            step(); mem_resp = 1'b1; #1;
            exp_v = {oh, 3'(k), 1'b1, 1'b0, oh, 1'b0};
            checks++;
            if (obs_a() !== exp_v) begin errors++; $display("FAIL sweep_%0d got %h exp %h", k, obs_a(), exp_v); end
            step(); req = req & ~oh; mem_resp = 1'b0; #1;
            exp_v = 22'h0;
            checks++;
            if (obs_a() !== exp_v) begin errors++; $display("FAIL sweep_idle_%0d got %h exp %h", k, obs_a(), exp_v); end
        end
    endtask

    task automatic test_wrap();
        req = 8'h10;
        step(); mem_resp = 1'b1; #1;
        exp_v = {8'h10, 3'd4, 1'b1, 1'b0, 8'h10, 1'b0};
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL wrap_serve4 got %h exp %h", obs_a(), exp_v); end
        step(); req = 8'h21; mem_resp = 1'b0;
        step(); #1;
        exp_v = {8'h20, 3'd5, 1'b1, 1'b0, 8'h00, 1'b0};
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL wrap_first got %h exp %h", obs_a(), exp_v); end
        mem_resp = 1'b1;
        step(); req = 8'h01; mem_resp = 1'b0;
        step(); #1;
        exp_v = {8'h01, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL wrap_second got %h exp %h", obs_a(), exp_v); end
        mem_resp = 1'b1;
        step(); req = 8'h00; mem_resp = 1'b0;
    endtask

    task automatic test_fixed_prio();
        test_reset();
        req = 8'h04;
        step(); mem_resp = 1'b1;
        step(); req = 8'h00; mem_resp = 1'b0;
        req = 8'h09;
        step(); #1;
        exp_v = {8'h01, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        checks++;
        if (obs_b() !== exp_v) begin errors++; $display("FAIL prio0_first got %h exp %h", obs_b(), exp_v); end
        exp_v = {8'h08, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0};
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL rr_contrast got %h exp %h", obs_a(), exp_v); end
        mem_resp = 1'b1;
        step(); req = 8'h08; mem_resp = 1'b0;
        step(); #1;
        exp_v = {8'h08, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0};
        checks++;
        if (obs_b() !== exp_v) begin errors++; $display("FAIL prio0_second got %h exp %h", obs_b(), exp_v); end
        mem_resp = 1'b1;
        step(); req = 8'h00; mem_resp = 1'b0;
    endtask

    task automatic test_timeout();
        test_reset();
        req = 8'h04; we = 8'h04;
        step();
        for (int c = 1; c <= 3; c++) begin
            #1;
            exp_v = {8'h04, 3'd2, 1'b0, 1'b1, 8'h00, 1'b0};
            checks++;
            if (obs_b() !== exp_v) begin errors++; $display("FAIL wd_busy_%0d got %h exp %h", c, obs_b(), exp_v); end
            step();
        end
        #1;
        exp_v = {8'h04, 3'd2, 1'b0, 1'b1, 8'h04, 1'b1};
        checks++;
        if (obs_b() !== exp_v) begin errors++; $display("FAIL wd_fire got %h exp %h", obs_b(), exp_v); end
        step(); req = 8'h00; we = 8'h00; #1;
        exp_v = 22'h0;
        checks++;
        if (obs_b() !== exp_v) begin errors++; $display("FAIL wd_idle got %h exp %h", obs_b(), exp_v); end

        test_reset();
        req = 8'h04;
        step(); step(); step(); step();
        mem_resp = 1'b1; #1;
        exp_v = {8'h04, 3'd2, 1'b1, 1'b0, 8'h04, 1'b0};
        checks++;
        if (obs_b() !== exp_v) begin errors++; $display("FAIL wd_coincide got %h exp %h", obs_b(), exp_v); end
        step(); req = 8'h00; #1;
        exp_v = 22'h0;
        checks++;
        if (obs_b() !== exp_v) begin errors++; $display("FAIL resp_in_idle got %h exp %h", obs_b(), exp_v); end
        step(); #1;
        checks++;
        if (obs_b() !== exp_v) begin errors++; $display("FAIL resp_in_idle2 got %h exp %h", obs_b(), exp_v); end
        mem_resp = 1'b0;
    endtask

    task automatic test_reset_busy();
        test_reset();
        req = 8'h04;
        step(); mem_resp = 1'b1;
        step(); req = 8'h00; mem_resp = 1'b0;
        req = 8'h10;
        step(); mem_resp = 1'b1; rst_n = 1'b0; #1;
        exp_v = {8'h10, 3'd4, 1'b1, 1'b0, 8'h00, 1'b0};
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL rst_no_done got %h exp %h", obs_a(), exp_v); end
        step(); #1;
        exp_v = 22'h0;
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL rst_abort got %h exp %h", obs_a(), exp_v); end
        rst_n = 1'b1; mem_resp = 1'b0; req = 8'h0A;
        step(); #1;
        exp_v = {8'h02, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0};
        checks++;
        if (obs_a() !== exp_v) begin errors++; $display("FAIL rst_ptr got %h exp %h", obs_a(), exp_v); end
        mem_resp = 1'b1;
        step(); req = 8'h00; mem_resp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_sweep();
        test_wrap();
        test_fixed_prio();
        test_timeout();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
